// File: rtl/masked_table_writer.sv
// Runtime loader for dual-port masked S-box BRAMs: packs byte pairs, writes even/odd per cycle.
// Optional READBACK_CHECK_EN adds an XOR readback check of the loaded table before done.
module masked_table_writer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              WEA,
  output logic [ADDR_W-1:0] ADDRA,
  output logic [DATA_W-1:0] DIA,
  output logic              WEB,
  output logic [ADDR_W-1:0] ADDRB,
  output logic [DATA_W-1:0] DIB,
`ifdef READBACK_CHECK_EN
  input  logic [DATA_W-1:0] DOA,
  input  logic [DATA_W-1:0] DOB,
  output logic              chk_err,
`endif
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DEPTH - 1);

`ifdef READBACK_CHECK_EN
  typedef enum logic [1:0] {StIdle, StEven, StOdd, StVerify} state_e;
  localparam logic [CntW-1:0] NumPairs = CntW'(DEPTH / 2);
`else
  typedef enum logic [1:0] {StIdle, StEven, StOdd, StDone} state_e;
`endif

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addra_q, addra_d, addrb_q, addrb_d;
  logic [DATA_W-1:0]   dia_q, dia_d, dib_q, dib_d;
  logic                hs;

`ifdef READBACK_CHECK_EN
  // rd_q: read address on the ports this cycle; p2_q: its data is on DOA/DOB
  logic                rd_q, rd_d, p1_q, p2_q;
  logic [DATA_W-1:0]   wrx_q, wrx_d, rdx_q, rdx_d;
  logic                chk_q, chk_d, last_rd, chk_now;

  assign last_rd = (state_q == StVerify) && p2_q && !p1_q;
  assign chk_now = (wrx_q != (rdx_q ^ DOA ^ DOB));
  assign chk_err = last_rd ? chk_now : chk_q;
  assign done    = last_rd;
`else
  assign done    = (state_q == StDone);
`endif

  assign din_ready = (state_q == StEven) || (state_q == StOdd);
  assign busy      = (state_q != StIdle);
  assign hs        = din_valid && din_ready;
  assign WEA       = we_q;
  assign WEB       = we_q;
  assign ADDRA     = addra_q;
  assign ADDRB     = addrb_q;
  assign DIA       = dia_q;
  assign DIB       = dib_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addra_d = addra_q;
    addrb_d = addrb_q;
    dia_d   = dia_q;
    dib_d   = dib_q;
`ifdef READBACK_CHECK_EN
    rd_d    = 1'b0;
    wrx_d   = wrx_q;
    rdx_d   = rdx_q;
    chk_d   = chk_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StEven;
          cnt_d   = '0;
`ifdef READBACK_CHECK_EN
          wrx_d   = '0;
          rdx_d   = '0;
          chk_d   = 1'b0;
`endif
        end
      end
      StEven: begin
        if (hs) begin
          hold_d  = din;
          cnt_d   = cnt_q + 1'b1;
          state_d = StOdd;
`ifdef READBACK_CHECK_EN
          wrx_d   = wrx_q ^ din;
`endif
        end
      end
      StOdd: begin
        if (hs) begin
          we_d    = 1'b1;
          addra_d = cnt_q[ADDR_W-1:0] - 1'b1;
          dia_d   = hold_q;
          addrb_d = cnt_q[ADDR_W-1:0];
          dib_d   = din;
          cnt_d   = cnt_q + 1'b1;
          state_d = StEven;
          if (cnt_q == LastIdx) begin
`ifdef READBACK_CHECK_EN
            state_d = StVerify;
            cnt_d   = '0;
`else
            state_d = StDone;
`endif
          end
`ifdef READBACK_CHECK_EN
          wrx_d   = wrx_q ^ din;
`endif
        end
      end
`ifdef READBACK_CHECK_EN
      StVerify: begin
        // First read goes out the cycle after the final write leaves the ports
        if (cnt_q != NumPairs) begin
          rd_d    = 1'b1;
          addra_d = {cnt_q[ADDR_W-2:0], 1'b0};
          addrb_d = {cnt_q[ADDR_W-2:0], 1'b1};
          cnt_d   = cnt_q + 1'b1;
        end
        if (p2_q) begin
          rdx_d = rdx_q ^ DOA ^ DOB;
        end
        if (last_rd) begin
          chk_d   = chk_now;
          state_d = StIdle;
        end
      end
`else
      StDone: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addra_q <= '0;
      addrb_q <= '0;
      dia_q   <= '0;
      dib_q   <= '0;
`ifdef READBACK_CHECK_EN
      rd_q    <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      wrx_q   <= '0;
      rdx_q   <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
      dia_q   <= dia_d;
      dib_q   <= dib_d;
`ifdef READBACK_CHECK_EN
      rd_q    <= rd_d;
      p1_q    <= rd_q;
      p2_q    <= p1_q;
      wrx_q   <= wrx_d;
      rdx_q   <= rdx_d;
      chk_q   <= chk_d;
`endif
    end
  end

endmodule
